// File: rtl/master_mux_locked_pkg.sv
// Shared types and helpers for the locked master-to-slave request mux.
package bus_mux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } mux_state_t;

  localparam int unsigned DEF_NUM_MASTERS    = 2;
  localparam int unsigned DEF_NUM_SLAVES     = 3;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Exactly one bit set; vectors wider than 32 bits are not supported.
  function automatic logic is_onehot(input logic [31:0] vec);
    return (vec != '0) && ((vec & (vec - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/master_mux_locked_if.sv
// Serial request bundle: per-master request inputs and per-slave forwarded requests.
interface master_mux_locked_if
  import bus_mux_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int unsigned NUM_SLAVES  = DEF_NUM_SLAVES
);
  logic [NUM_MASTERS-1:0] m_master_ready;
  logic [NUM_MASTERS-1:0] m_master_valid;
  logic [NUM_MASTERS-1:0] m_read_en;
  logic [NUM_MASTERS-1:0] m_write_en;
  logic [NUM_MASTERS-1:0] m_tx_address;
  logic [NUM_MASTERS-1:0] m_tx_data;
  logic [NUM_MASTERS-1:0] m_tx_burst;

  logic [NUM_SLAVES-1:0] to_slave_master_ready;
  logic [NUM_SLAVES-1:0] to_slave_master_valid;
  logic [NUM_SLAVES-1:0] to_slave_read_en;
  logic [NUM_SLAVES-1:0] to_slave_write_en;
  logic [NUM_SLAVES-1:0] to_slave_tx_address;
  logic [NUM_SLAVES-1:0] to_slave_tx_data;
  logic [NUM_SLAVES-1:0] to_slave_tx_burst;

  modport master (
    output m_master_ready, m_master_valid, m_read_en, m_write_en,
           m_tx_address, m_tx_data, m_tx_burst,
    input  to_slave_master_ready, to_slave_master_valid, to_slave_read_en,
           to_slave_write_en, to_slave_tx_address, to_slave_tx_data, to_slave_tx_burst
  );

  modport slave (
    input  m_master_ready, m_master_valid, m_read_en, m_write_en,
           m_tx_address, m_tx_data, m_tx_burst,
    output to_slave_master_ready, to_slave_master_valid, to_slave_read_en,
           to_slave_write_en, to_slave_tx_address, to_slave_tx_data, to_slave_tx_burst
  );
endinterface

// File: rtl/master_mux_locked_grant_onehot_enc.sv
// One-hot grant vector to binary index, plus a strict one-hot flag.
module grant_onehot_enc
  import bus_mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 2,
  localparam int unsigned IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] grant,
  output logic [IDX_W-1:0] index,
  output logic             onehot
);

  always_comb begin
    index = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (grant[i]) index = index | IDX_W'(i);
    end
  end

  assign onehot = is_onehot(32'(grant));

endmodule

// File: rtl/master_mux_locked.sv
// Registered master-to-slave request mux with the route locked for a whole transaction.
// Optional forced release after TIMEOUT_CYCLES active cycles: define MASTER_MUX_TIMEOUT_EN.
module master_mux_locked
  import bus_mux_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter  int unsigned NUM_SLAVES     = DEF_NUM_SLAVES,
  parameter  int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int unsigned MW = idx_width(NUM_MASTERS),
  localparam int unsigned SW = idx_width(NUM_SLAVES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] bus_grant,
  input  logic [NUM_SLAVES-1:0]  slave_grant,
  master_mux_locked_if.slave     bus,
  output logic                   route_busy,
  output logic [MW-1:0]          route_master,
  output logic [SW-1:0]          route_slave,
  output logic                   grant_error,
  output logic                   timeout
);

  if (NUM_MASTERS < 2 || NUM_SLAVES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("master_mux_locked: illegal parameter set");
  end

  mux_state_t            state, state_nx;
  logic [MW-1:0]         m_idx, sel_m;
  logic [SW-1:0]         s_idx, dest;
  logic                  m_onehot, s_onehot;
  logic                  capture, fwd, malformed, at_limit, to_hit;
  logic [NUM_SLAVES-1:0] dest_mask;
  logic                  b_ready, b_valid, b_rd, b_wr, b_addr, b_data, b_burst;

  grant_onehot_enc #(.WIDTH(NUM_MASTERS)) u_master_enc (
    .grant(bus_grant), .index(m_idx), .onehot(m_onehot)
  );

  grant_onehot_enc #(.WIDTH(NUM_SLAVES)) u_slave_enc (
    .grant(slave_grant), .index(s_idx), .onehot(s_onehot)
  );

  // Live grants choose the route only on the capture beat; afterwards the latched route does.
  assign sel_m = (state == IDLE) ? m_idx : route_master;
  assign dest  = (state == IDLE) ? s_idx : route_slave;

  assign b_ready = bus.m_master_ready[sel_m];
  assign b_valid = bus.m_master_valid[sel_m];
  assign b_rd    = bus.m_read_en[sel_m];
  assign b_wr    = bus.m_write_en[sel_m];
  assign b_addr  = bus.m_tx_address[sel_m];
  assign b_data  = bus.m_tx_data[sel_m];
  assign b_burst = bus.m_tx_burst[sel_m];

`ifdef MASTER_MUX_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] act_cnt;

  // Limit is hit on the edge that would bring the count to TIMEOUT_CYCLES.
  assign at_limit = (state == ACTIVE) && (act_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || capture) act_cnt <= '0;
    else if (state == ACTIVE) act_cnt <= act_cnt + CW'(1);
  end
`else
  assign at_limit = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    capture   = 1'b0;
    fwd       = 1'b0;
    malformed = 1'b0;
    to_hit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (m_onehot && s_onehot && b_valid) begin
          capture  = 1'b1;
          fwd      = 1'b1;
          state_nx = ACTIVE;
        end else begin
          malformed = (|bus.m_master_valid) && (|bus_grant) && !(m_onehot && s_onehot);
        end
      end
      ACTIVE: begin
        if (at_limit) begin
          to_hit   = 1'b1;
          state_nx = DRAIN;
        end else begin
          fwd = 1'b1;
          if (!b_valid) state_nx = DRAIN;
        end
      end
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    dest_mask = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      dest_mask[i] = fwd && (dest == SW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= IDLE;
      route_busy                <= 1'b0;
      route_master              <= '0;
      route_slave               <= '0;
      grant_error               <= 1'b0;
      timeout                   <= 1'b0;
      bus.to_slave_master_ready <= '0;
      bus.to_slave_master_valid <= '0;
      bus.to_slave_read_en      <= '0;
      bus.to_slave_write_en     <= '0;
      bus.to_slave_tx_address   <= '0;
      bus.to_slave_tx_data      <= '0;
      bus.to_slave_tx_burst     <= '0;
    end else begin
      state       <= state_nx;
      route_busy  <= (state_nx != IDLE);
      grant_error <= malformed;
      timeout     <= to_hit;
      if (capture) begin
        route_master <= m_idx;
        route_slave  <= s_idx;
      end
      bus.to_slave_master_ready <= dest_mask & {NUM_SLAVES{b_ready}};
      bus.to_slave_master_valid <= dest_mask & {NUM_SLAVES{b_valid}};
      bus.to_slave_read_en      <= dest_mask & {NUM_SLAVES{b_rd}};
      bus.to_slave_write_en     <= dest_mask & {NUM_SLAVES{b_wr}};
      bus.to_slave_tx_address   <= dest_mask & {NUM_SLAVES{b_addr}};
      bus.to_slave_tx_data      <= dest_mask & {NUM_SLAVES{b_data}};
      bus.to_slave_tx_burst     <= dest_mask & {NUM_SLAVES{b_burst}};
    end
  end

endmodule
